bdd_top: RTL and testbench
==========================

# bdd_top

Oblique decision-tree (BDD) classifier accelerator. Two on-chip node memories hold the tree and are loaded through a write port. After a synchronous reset, the block walks the tree from node 0 for the 3-attribute input vector. At each node it compares a weighted attribute sum against a threshold, and at a leaf it drives the 8-bit class onto out_class.

## Interface
- RAM1_DATA_WIDTH, 34: node-condition word, {w0[7:0], w1[7:0], w2[7:0], thr[9:0]}
- RAM2_DATA_WIDTH, 18: node-link word, {upper child[8:0], lower child[8:0]}
- ADDR_WIDTH, 8: write-address width
- DEPTH, 32: entries per memory; power of two
- clk  in  1  sole clock, rising edge
- rst_in  in  1  reset, synchronous, active-high
- we1  in  1  load enable; writes both memories, holds traversal
- in_addr  in  ADDR_WIDTH  load address
- ram1_data_in  in  RAM1_DATA_WIDTH  condition word to write
- ram2_data_in  in  RAM2_DATA_WIDTH  link word to write
- in_attr  in  24  {a0[23:16], a1[15:8], a2[7:0]}, unsigned
- out_class  out  8  class of last leaf reached

## Operation
- Load: on each clk edge with we1=1, RAM1[in_addr mod DEPTH] <= ram1_data_in and RAM2[in_addr mod DEPTH] <= ram2_data_in. Memories are not cleared by reset.
- Child field (9 bits): bit8=1 means leaf, with class = bits7:0. bit8=0 means internal node, with address = bits7:0 (taken mod DEPTH).
- Node evaluation: sum = w0*a0 + w1*a1 + w2*a2, unsigned, 18 bits wide with no overflow.
  - If sum <= zero-extended thr, take the upper child (bits17:9); otherwise take the lower child (bits8:0).
- FSM has 2 states:
  - FETCH: issue read of node pointer (synchronous-read memories).
  - EVAL: read data valid; compute and select the child.
    - Internal child: node <= child addr, go to FETCH.
    - Leaf: out_class <= class, node <= 0, go to FETCH. Classification repeats continuously using the current in_attr.
- in_attr is sampled combinationally in EVAL. Changing it mid-walk affects the remaining nodes only.
- we1=1: state forced to FETCH, node=0, out_class held.
- Reset values: state=FETCH, node=0, out_class=0. Reset mid-walk aborts the walk and clears out_class. Reset has priority over we1 for control state; memory writes still occur if we1=1.

## Timing
- 2 cycles per tree level. First walk after rst_in falls: out_class valid at the end of cycle 2·L, where L is the number of nodes visited.
- out_class changes only in EVAL at a leaf. It is stable otherwise.
- Load writes take effect on the edge. A read of the same address in the next FETCH returns new data.
- No handshake. The consumer waits ≥ 2·(tree depth) cycles after reset or an attribute change.

## Structure
- Package bdd_pkg: field offsets (W0/W1/W2/THR slices, UPPER/LOWER child slices), LEAF_BIT=8, SUM_W=18, state enum {FETCH, EVAL}.
- One sub-module, bdd_node_ram: parameterized width/depth single-port RAM with synchronous write and synchronous read. It is instantiated twice (34-bit and 18-bit).
- Top holds the FSM, MAC/compare datapath and child decode.

## Test plan
Tree used by all scenarios below (addr: w0,w1,w2,thr / upper,lower):

| Addr | w0 | w1 | w2 | thr | upper | lower |
|---|---|---|---|---|---|---|
| 0 | 10 | 0 | 0 | 245 | leaf3 | n1 |
| 1 | 0 | 10 | 0 | 175 | n2 | n3 |
| 2 | 10 | 0 | 0 | 495 | n4 | n5 |
| 3 | 10 | 0 | 0 | 485 | n6 | leaf1 |
| 4 | 0 | 10 | 0 | 165 | leaf1 | leaf2 |
| 5 | 0 | 10 | 0 | 155 | leaf2 | n7 |
| 6 | 0 | 0 | 10 | 595 | leaf1 | leaf3 |
| 7 | 0 | 0 | 10 | 695 | leaf1 | leaf3 |

- Load the tree above, rst_in pulse, in_attr={14,2,49} -> out_class=3 after 2 cycles. Before that, out_class=0.
- in_attr={30,2,49} -> path 0→1→2→4 -> out_class=1 after 8 cycles.
- in_attr={30,20,60} -> path 0→1→3→6 -> out_class=3 after 8 cycles. in_attr={30,20,0} -> out_class=1.
- Boundary: in_attr={24,0,0} with node0 thr=240 -> sum==thr -> upper -> out_class=3. Max weights and attributes (255×3) give sum=195075 with no wrap.
- Assert rst_in mid-walk -> out_class=0 next cycle, walk restarts at node 0. we1=1 mid-walk -> out_class frozen, new data used after we1 falls.

Source files
------------

// File: rtl/bdd_pkg.sv
// Shared definitions for the oblique decision-tree classifier: node word
// field positions, datapath widths, FSM state encoding and the MAC helper.
package bdd_pkg;

    localparam int W0_HI    = 33;
    localparam int W0_LO    = 26;
    localparam int W1_HI    = 25;
    localparam int W1_LO    = 18;
    localparam int W2_HI    = 17;
    localparam int W2_LO    = 10;
    localparam int THR_HI   = 9;
    localparam int THR_LO   = 0;

    localparam int UPPER_HI = 17;
    localparam int UPPER_LO = 9;
    localparam int LOWER_HI = 8;
    localparam int LOWER_LO = 0;

    localparam int LEAF_BIT = 8;
    localparam int CHILD_W  = 9;
    localparam int SUM_W    = 18;

    typedef enum logic {
        FETCH = 1'b0,
        EVAL  = 1'b1
    } state_t;

    // 3 x 255 x 255 = 195075 fits in SUM_W bits, so the sum never wraps.
    function automatic logic [SUM_W-1:0] mac3(
        input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
        input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2
    );
        return SUM_W'(w0) * SUM_W'(a0)
             + SUM_W'(w1) * SUM_W'(a1)
             + SUM_W'(w2) * SUM_W'(a2);
    endfunction

endpackage

// File: rtl/bdd_node_ram.sv
// Single-port node memory: synchronous write, synchronous (read-first) read.
module bdd_node_ram #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bdd_top.sv
// Oblique decision-tree walker: two-state FETCH/EVAL loop over the node
// memories, continuously reclassifying the current attribute vector.
module bdd_top
    import bdd_pkg::*;
#(
    parameter int RAM1_DATA_WIDTH = 34,
    parameter int RAM2_DATA_WIDTH = 18,
    parameter int ADDR_WIDTH      = 8,
    parameter int DEPTH           = 32
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       we1,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
    input  logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
    input  logic [23:0]                in_attr,
    output logic [7:0]                 out_class
);

    localparam int AW = $clog2(DEPTH);

    state_t               state_q, state_d;
    logic [AW-1:0]        node_q, node_d;
    logic [7:0]           class_q, class_d;

    logic [AW-1:0]              ram_addr;
    logic [RAM1_DATA_WIDTH-1:0] cond_word;
    logic [RAM2_DATA_WIDTH-1:0] link_word;
    logic [SUM_W-1:0]           sum;
    logic [CHILD_W-1:0]         child;
    logic                       unused_addr_bits;

    // Loading borrows the memory port; otherwise the walker reads its node.
    assign ram_addr = we1 ? in_addr[AW-1:0] : node_q;
    assign unused_addr_bits = ^in_addr[ADDR_WIDTH-1:AW];

    bdd_node_ram #(.WIDTH(RAM1_DATA_WIDTH), .DEPTH(DEPTH)) u_cond_ram (
        .clk     (clk),
        .we      (we1),
        .addr    (ram_addr),
        .wr_data (ram1_data_in),
        .rd_data (cond_word)
    );

    bdd_node_ram #(.WIDTH(RAM2_DATA_WIDTH), .DEPTH(DEPTH)) u_link_ram (
        .clk     (clk),
        .we      (we1),
        .addr    (ram_addr),
        .wr_data (ram2_data_in),
        .rd_data (link_word)
    );

    always_comb begin
        sum = mac3(cond_word[W0_HI:W0_LO], cond_word[W1_HI:W1_LO],
                   cond_word[W2_HI:W2_LO],
                   in_attr[23:16], in_attr[15:8], in_attr[7:0]);
        if (sum <= SUM_W'(cond_word[THR_HI:THR_LO])) begin
            child = link_word[UPPER_HI:UPPER_LO];
        end else begin
            child = link_word[LOWER_HI:LOWER_LO];
        end
    end

    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        class_d = class_q;
        if (we1) begin
            state_d = FETCH;
            node_d  = '0;
        end else begin
            case (state_q)
                FETCH: state_d = EVAL;
                EVAL: begin
                    state_d = FETCH;
                    if (child[LEAF_BIT]) begin
                        class_d = child[7:0];
                        node_d  = '0;
                    end else begin
                        node_d  = child[AW-1:0];
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= FETCH;
            node_q  <= '0;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            class_q <= class_d;
        end
    end

    assign out_class = class_q;

endmodule

// File: tb/tb_bdd_top.sv
// Self-checking bench for bdd_top: a behavioural tree walker predicts each
// classification, and expected results are queued and checked at their due cycle.
module tb_bdd_top;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        we1;
    logic [7:0]  in_addr;
    logic [33:0] ram1_data_in;
    logic [17:0] ram2_data_in;
    logic [23:0] in_attr;
    logic [7:0]  out_class;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] cls;
        int         lat;
    } exp_t;

    exp_t sb[$];

    logic [33:0] m1 [32];
    logic [17:0] m2 [32];

    bdd_top dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .we1          (we1),
        .in_addr      (in_addr),
        .ram1_data_in (ram1_data_in),
        .ram2_data_in (ram2_data_in),
        .in_attr      (in_attr),
        .out_class    (out_class)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] leaf(input int c);
        return {1'b1, 8'(c)};
    endfunction

    function automatic logic [8:0] nd(input int n);
        return {1'b0, 8'(n)};
    endfunction

    task automatic loadNode(input int addr, input int w0, input int w1, input int w2,
                            input int thr, input logic [8:0] up, input logic [8:0] lo);
        we1          = 1'b1;
        in_addr      = 8'(addr);
        ram1_data_in = {8'(w0), 8'(w1), 8'(w2), 10'(thr)};
        ram2_data_in = {up, lo};
        m1[addr]     = ram1_data_in;
        m2[addr]     = ram2_data_in;
        tick();
        we1 = 1'b0;
    endtask

    function automatic void modelWalk(input logic [23:0] attr, output logic [7:0] cls, output int lat);
        int node;
        int s;
        logic [8:0] link;
        node = 0;
        lat  = 0;
        cls  = 8'd0;
        for (int i = 0; i < 32; i++) begin
            s = int'(m1[node][33:26]) * int'(attr[23:16])
              + int'(m1[node][25:18]) * int'(attr[15:8])
              + int'(m1[node][17:10]) * int'(attr[7:0]);
            lat += 2;
            link = (s <= int'(m1[node][9:0])) ? m2[node][17:9] : m2[node][8:0];
            if (link[8]) begin
                cls = link[7:0];
                return;
            end
            node = int'(link[4:0]);
        end
    endfunction

    task automatic applyStimulus(input string tag, input logic [23:0] attr,
                                 input logic [7:0] exp_cls, input int exp_lat);
        exp_t e;
        rst_in = 1'b1;
        tick();
        checkOutput({tag, "_reset"}, out_class, 8'd0);
        rst_in  = 1'b0;
        in_attr = attr;
        e.tag = tag;
        e.cls = exp_cls;
        e.lat = exp_lat;
        sb.push_back(e);
    endtask

    task automatic runWalk(input logic [7:0] prev);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        repeat (e.lat - 1) tick();
        checkOutput({e.tag, "_early"}, out_class, prev);
        tick();
        checkOutput(e.tag, out_class, e.cls);
    endtask

    task automatic modelStimulus(input string tag, input logic [23:0] attr);
        logic [7:0] c;
        int l;
        modelWalk(attr, c, l);
        applyStimulus(tag, attr, c, l);
    endtask

    initial begin
        exp_t e;
        logic [7:0] c;
        int l;

        rst_in       = 1'b1;
        we1          = 1'b0;
        in_addr      = '0;
        ram1_data_in = '0;
        ram2_data_in = '0;
        in_attr      = '0;
        tick();
        checkOutput("power_on_reset", out_class, 8'd0);

        loadNode(0, 10, 0, 0, 245, leaf(3), nd(1));
        loadNode(1, 0, 10, 0, 175, nd(2), nd(3));
        loadNode(2, 10, 0, 0, 495, nd(4), nd(5));
        loadNode(3, 10, 0, 0, 485, nd(6), leaf(1));
        loadNode(4, 0, 10, 0, 165, leaf(1), leaf(2));
        loadNode(5, 0, 10, 0, 155, leaf(2), nd(7));
        loadNode(6, 0, 0, 10, 595, leaf(1), leaf(3));
        loadNode(7, 0, 0, 10, 695, leaf(1), leaf(3));
        tick();
        checkOutput("load_under_reset", out_class, 8'd0);

        applyStimulus("root_leaf", {8'd14, 8'd2, 8'd49}, 8'd3, 2);
        runWalk(8'd0);
        applyStimulus("path_0124", {8'd30, 8'd2, 8'd49}, 8'd1, 8);
        runWalk(8'd0);
        applyStimulus("path_0136", {8'd30, 8'd20, 8'd60}, 8'd3, 8);
        runWalk(8'd0);
        applyStimulus("path_0136_low", {8'd30, 8'd20, 8'd0}, 8'd1, 8);
        runWalk(8'd0);

        // The tree keeps reclassifying: a second walk must reproduce the class.
        repeat (8) tick();
        checkOutput("repeat_walk", out_class, 8'd1);

        for (int i = 0; i < 6; i++) begin
            modelStimulus($sformatf("random_%0d", i),
                          {8'($urandom_range(0, 60)), 8'($urandom_range(0, 30)),
                           8'($urandom_range(0, 80))});
            runWalk(8'd0);
        end

        applyStimulus("pre_we1", {8'd30, 8'd2, 8'd49}, 8'd1, 8);
        runWalk(8'd0);
        repeat (3) tick();
        we1          = 1'b1;
        in_addr      = 8'd4;
        ram1_data_in = {8'd0, 8'd10, 8'd0, 10'd165};
        ram2_data_in = {leaf(7), leaf(2)};
        m1[4]        = ram1_data_in;
        m2[4]        = ram2_data_in;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("we1_hold_%0d", i), out_class, 8'd1);
        end
        we1 = 1'b0;
        modelWalk(in_attr, c, l);
        e.tag = "we1_new_data";
        e.cls = c;
        e.lat = l;
        sb.push_back(e);
        runWalk(8'd1);

        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        checkOutput("rst_mid_walk", out_class, 8'd0);
        rst_in = 1'b0;
        e.tag = "rst_restart";
        e.cls = 8'd7;
        e.lat = 8;
        sb.push_back(e);
        runWalk(8'd0);

        rst_in = 1'b1;
        loadNode(0, 10, 0, 0, 240, leaf(3), nd(1));
        applyStimulus("thr_equal", {8'd24, 8'd0, 8'd0}, 8'd3, 2);
        runWalk(8'd0);

        rst_in = 1'b1;
        loadNode(0, 255, 255, 255, 600, leaf(5), leaf(6));
        applyStimulus("max_sum", {8'd255, 8'd255, 8'd255}, 8'd6, 2);
        runWalk(8'd0);
        modelStimulus("max_sum_small", {8'd1, 8'd1, 8'd1});
        runWalk(8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
